// File: rtl/key_pkg.sv
// Shared constants for the front-panel key debouncer.
// Holds default timing values, the auto-repeat FSM encoding and the board key map.
package key_pkg;

    // Default timing, in delay_clock ticks
    localparam int unsigned DEF_DEBOUNCE_TICKS = 20;
    localparam int unsigned DEF_HOLD_TICKS     = 500;
    localparam int unsigned DEF_REPEAT_TICKS   = 100;

    // Auto-repeat state per key
    typedef enum logic {
        IDLE   = 1'b0,
        REPEAT = 1'b1
    } rpt_state_e;

    // Board key positions on key_raw_n
    localparam int unsigned KEY_RESET = 0;
    localparam int unsigned KEY_LOAD  = 1;
    localparam int unsigned KEY_RUN   = 2;
    localparam int unsigned KEY_AUX   = 3;

endpackage

// File: rtl/key_debounce_cell.sv
// Single-key debounce cell: 2-flop synchroniser, tick-based debounce counter,
// registered level plus one-cycle press/release pulses.
// Optional auto-repeat of the press pulse while held: define KEY_AUTOREPEAT_EN.
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned HOLD_TICKS     = DEF_HOLD_TICKS,
    parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic key_raw_n_i,
    output logic level_o,
    output logic level_next_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    // The flops carry the inverted (active-high) key so that the reset value
    // 0 already means "released" and nothing starts counting out of reset.
    logic             sync1_q, sync2_q;
    logic             key_sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             edge_press;
    logic             rpt_fire;

    assign key_sync = sync2_q;

    // Bring the asynchronous key into the clock domain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~key_raw_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce rule: a differing level must survive DEBOUNCE_TICKS ticks
    always_comb begin
        cnt_d      = cnt_q;
        level_d    = level_q;
        edge_press = 1'b0;
        release_d  = 1'b0;
        if (key_sync == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == DB_LAST) begin
                level_d    = key_sync;
                cnt_d      = '0;
                edge_press = key_sync;
                release_d  = ~key_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_d = edge_press | rpt_fire;

    // Debounce state and registered pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_TICKS - 1);

    rpt_state_e  state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        hold_hit;

    // The terminal count depends on whether the first repeat has happened yet
    assign hold_hit = (state_q == IDLE) ? (hold_q == HOLD_LAST) : (hold_q == REPEAT_LAST);

    // Repeat FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Repeat FSM next state: count ticks while held, restart on each repeat
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!level_q) begin
            state_d = IDLE;
            hold_d  = '0;
        end else if (tick_i) begin
            if (hold_hit) begin
                state_d = REPEAT;
                hold_d  = '0;
            end else begin
                hold_d = hold_q + 16'd1;
            end
        end
    end

    // Repeat FSM output: never repeat in the cycle a release is accepted
    always_comb begin
        rpt_fire = level_q & tick_i & hold_hit & ~release_d;
    end
`else
    localparam int unsigned rpt_cfg_unused = HOLD_TICKS + REPEAT_TICKS;

    // No auto-repeat: presses come only from the debounced edge
    always_comb begin
        rpt_fire = 1'b0;
    end
`endif

    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign press_o      = press_q;
    assign release_o    = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Front-panel key input block: one debounce cell per active-low board key,
// plus a registered "any key pressed" flag aligned with key_level.
// Optional auto-repeat (in each cell): define KEY_AUTOREPEAT_EN.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned KEY_NUM        = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned HOLD_TICKS     = DEF_HOLD_TICKS,
    parameter int unsigned REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic               sysclk,
    input  logic               gen_reset,
    input  logic               delay_clock,
    input  logic [KEY_NUM-1:0] key_raw_n,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic               key_any
);

    logic [KEY_NUM-1:0] level_next;
    logic               key_any_q;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        key_debounce_cell #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .HOLD_TICKS     (HOLD_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_cell (
            .clk_i        (sysclk),
            .rst_i        (gen_reset),
            .tick_i       (delay_clock),
            .key_raw_n_i  (key_raw_n[k]),
            .level_o      (key_level[k]),
            .level_next_o (level_next[k]),
            .press_o      (key_press[k]),
            .release_o    (key_release[k])
        );
    end

    // OR of the next levels so the flag changes in the same cycle as key_level
    always_ff @(posedge sysclk or posedge gen_reset) begin
        if (gen_reset) begin
            key_any_q <= 1'b0;
        end else begin
            key_any_q <= |level_next;
        end
    end

    assign key_any = key_any_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (default build, DEBOUNCE_TICKS=20).
module tb_key_debouncer;

    localparam int KN = 4;
    localparam int DT = 20;

    logic          sysclk = 1'b0;
    logic          gen_reset;
    logic          delay_clock;
    logic [KN-1:0] key_raw_n;
    logic [KN-1:0] key_level;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic          key_any;

    key_debouncer #(
        .KEY_NUM        (KN),
        .CNT_W          (8),
        .DEBOUNCE_TICKS (DT),
        .HOLD_TICKS     (500),
        .REPEAT_TICKS   (100)
    ) dut (
        .sysclk      (sysclk),
        .gen_reset   (gen_reset),
        .delay_clock (delay_clock),
        .key_raw_n   (key_raw_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit rand_tick = 1'b0;

    // Reference: per key, the pressed value seen after a 2-cycle sync delay,
    // the accepted level, and how many ticks in a row the synced value has
    // disagreed with that level.
    bit m_pipe [KN][2];
    bit m_lvl  [KN];
    int m_run  [KN];
    logic [KN-1:0] m_press, m_rel, m_level_v;
    bit m_any;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < KN; k++) begin
            m_pipe[k][0] = 1'b0;
            m_pipe[k][1] = 1'b0;
            m_lvl[k]     = 1'b0;
            m_run[k]     = 0;
        end
        m_press   = '0;
        m_rel     = '0;
        m_level_v = '0;
        m_any     = 1'b0;
    endtask

    task automatic model_update(input logic [KN-1:0] raw_n, input bit dc);
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < KN; k++) begin
            bit seen;
            seen         = m_pipe[k][1];
            m_pipe[k][1] = m_pipe[k][0];
            m_pipe[k][0] = !raw_n[k];
            if (seen == m_lvl[k]) begin
                m_run[k] = 0;
            end else if (dc) begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == DT) begin
                    m_lvl[k] = seen;
                    m_run[k] = 0;
                    if (seen) m_press[k] = 1'b1;
                    else      m_rel[k]   = 1'b1;
                end
            end
        end
        for (int k = 0; k < KN; k++) m_level_v[k] = m_lvl[k];
        m_any = |m_level_v;
    endtask

    task automatic compare_all();
        check_eq("key_level", 32'(key_level), 32'(m_level_v));
        check_eq("key_press", 32'(key_press), 32'(m_press));
        check_eq("key_release", 32'(key_release), 32'(m_rel));
        check_eq("key_any", 32'(key_any), 32'(m_any));
        check_eq("press_and_release", 32'(key_press & key_release), 32'd0);
    endtask

    // One clock: capture inputs, clock edge, update model, compare, drive next tick
    task automatic step();
        logic [KN-1:0] raw_c;
        bit dc_c, rst_c;
        raw_c = key_raw_n;
        dc_c  = delay_clock;
        rst_c = gen_reset;
        @(posedge sysclk);
        cyc++;
        if (rst_c) model_reset();
        else       model_update(raw_c, dc_c);
        #1;
        compare_all();
        if (rand_tick) delay_clock = ($urandom_range(0, 3) == 0);
        else           delay_clock = ((cyc % 4) == 3);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset_check();
        gen_reset = 1'b1;
        #1;
        model_reset();
        compare_all();
    endtask

    int hold_left [KN];

    initial begin
        gen_reset   = 1'b1;
        delay_clock = 1'b0;
        key_raw_n   = '1;
        model_reset();
        #1;
        compare_all();
        steps(5);
        gen_reset = 1'b0;
        steps(1000);

        // Steady press on key 0
        key_raw_n[0] = 1'b0;
        steps(120);

        // Key 1 low for 19 ticks only: must be discarded
        key_raw_n[1] = 1'b0;
        steps(19 * 4);
        key_raw_n[1] = 1'b1;
        steps(40);

        // Keys 2 and 3 together, released 50 ticks later
        key_raw_n[3:2] = 2'b00;
        steps(50 * 4);
        key_raw_n[3:2] = 2'b11;
        steps(120);

        // Reset mid-count on key 1 while key 0 stays held
        key_raw_n[1] = 1'b0;
        steps(2 + 10 * 4);
        async_reset_check();
        steps(3);
        gen_reset = 1'b0;
        steps(150);
        key_raw_n = '1;
        steps(120);

        // Random key activity with random tick spacing
        rand_tick = 1'b1;
        for (int k = 0; k < KN; k++) hold_left[k] = $urandom_range(1, 120);
        for (int i = 0; i < 15000; i++) begin
            for (int k = 0; k < KN; k++) begin
                hold_left[k]--;
                if (hold_left[k] <= 0) begin
                    key_raw_n[k] = ~key_raw_n[k];
                    hold_left[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60)
                                                                : $urandom_range(60, 200);
                end
            end
            if ($urandom_range(0, 2999) == 0) begin
                async_reset_check();
                step();
                gen_reset = 1'b0;
            end
            step();
        end
        key_raw_n = '1;
        steps(400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Front-panel push-button input block. It is the input-side counterpart of the segment indicator: the indicator drives the board's front panel, this block reads the panel keys.
- It synchronises KEY_NUM raw active-low board keys into sysclk and debounces each one against the shared delay_clock tick.
- Outputs are a clean level per key plus one-cycle press and release pulses. These feed the console's reset/load/run control logic.

Parameters:
- KEY_NUM, 4, number of keys, 1..8.
- CNT_W, 8, width of each per-key debounce counter.
- DEBOUNCE_TICKS, 8'd20, delay_clock ticks a new level must hold before it is accepted, 1..2^CNT_W-1.
- HOLD_TICKS, 16'd500, ticks a key must stay pressed before auto-repeat starts (optional feature only).
- REPEAT_TICKS, 16'd100, ticks between auto-repeat pulses (optional feature only).

Ports:
- sysclk  in  1  system clock.
- gen_reset  in  1  asynchronous, active-high reset.
- delay_clock  in  1  tick enable, one sysclk wide, the same tick the indicator uses.
- key_raw_n  in  KEY_NUM  raw board keys, active-low, asynchronous.
- key_level  out  KEY_NUM  debounced state, 1 = pressed.
- key_press  out  KEY_NUM  one-sysclk pulse on an accepted press.
- key_release  out  KEY_NUM  one-sysclk pulse on an accepted release.
- key_any  out  1  OR of key_level.

Behaviour:
- Reset: when gen_reset is asserted, asynchronously clear all of the following to 0:
  - synchroniser flops, counters, key_level, key_press, key_release, key_any;
  - repeat state.
  - 0 means released, so a key held through reset produces a press pulse after the debounce time.
- Synchroniser: each key goes through two flops on sysclk, and the result is inverted: key_sync = ~key_raw_n after the 2 flops.
- Per-key rules, evaluated every sysclk:
  - key_sync == key_level: counter <= 0. A glitch shorter than the debounce time is discarded.
  - key_sync != key_level and delay_clock = 0: counter holds.
  - key_sync != key_level, delay_clock = 1 and counter == DEBOUNCE_TICKS-1: key_level <= key_sync, counter <= 0. Pulse key_press if the new level is 1, key_release if it is 0.
  - key_sync != key_level, delay_clock = 1, any other counter value: counter <= counter+1.
- Pulse outputs:
  - key_press and key_release are registered, high for exactly one sysclk, and assert in the same cycle key_level changes.
  - They are never both high for the same key.
- Latency from a clean raw edge: 2 sysclk, plus DEBOUNCE_TICKS delay_clock ticks, plus 1 sysclk.
- The counter never wraps: it is bounded by DEBOUNCE_TICKS-1 < 2^CNT_W.
- Keys are fully independent. Any number of keys may change in the same cycle, and each pulses independently.
- key_any is registered and equals the OR of the next key_level, so it is cycle-aligned with key_level.
- Reset mid-count: the count is lost and the key is treated as released on exit from reset.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- With the macro defined, each key has a 16-bit hold counter and a two-state FSM, states IDLE and REPEAT:
  - While key_level = 1, the hold counter counts delay_clock ticks.
  - On reaching HOLD_TICKS-1: pulse key_press once, zero the hold counter, go to REPEAT.
  - In REPEAT: pulse key_press each time the counter reaches REPEAT_TICKS-1.
  - key_level = 0 or gen_reset returns the FSM to IDLE with the counter at 0.
  - The release pulse is unchanged.
- Without the macro: no hold logic is built, and key_press fires only on the debounced press edge.

Decomposition:
- Package key_pkg:
  - default constants (DEBOUNCE_TICKS, HOLD_TICKS, REPEAT_TICKS);
  - repeat-FSM state encoding (IDLE=1'b0, REPEAT=1'b1);
  - board key index constants KEY_RESET=0, KEY_LOAD=1, KEY_RUN=2, KEY_AUX=3.
- One natural sub-module, key_debounce_cell: synchroniser, counter, level/pulse logic and the optional repeat logic for a single key.
- The top level instantiates KEY_NUM cells and the key_any OR.

Test Plan:
- Reset with key_raw_n=4'hF, then release reset → all outputs 0; no pulses for 1000 sysclk.
- key_raw_n[0] low steadily, delay_clock every 4 sysclk, DEBOUNCE_TICKS=20 → key_level[0] rises after 2 sysclk, 20 ticks and 1 sysclk. key_press[0] is high for 1 cycle in the same cycle. key_any=1.
- key_raw_n[1] low for 19 ticks then high → key_level[1] stays 0; no press or release pulse; counter back to 0.
- Keys 2 and 3 pressed in the same cycle, released 50 ticks later → simultaneous key_press[3:2]=2'b11, later simultaneous key_release[3:2]=2'b11; key_any falls in the cycle of the release.
- gen_reset asserted at tick 10 of a press count, released, key still held → outputs clear asynchronously; the press is accepted a full 20 ticks after reset releases.
- With KEY_AUTOREPEAT_EN, HOLD_TICKS=500, REPEAT_TICKS=100, key held 800 ticks → press pulses at debounce, +500 and +600 ticks, +700 and +800 ticks; a single release pulse; none after release.
